// File: rtl/mips_bus_checker_if.sv
// Bus bundle between the MIPS data-memory bus checker and its surroundings.
// It carries the run control, the CPU bus being observed, the vector ROM
// port, and the result flags. Signals are prefixed from the checker's side.
interface mips_bus_checker_if #(
  parameter int LOGWIDTH  = 5,
  parameter int DEPTH_LOG = 10
);
  localparam int W = 2**LOGWIDTH;

  logic                 i_start;
  logic [W-1:0]         i_dut_wd;
  logic [W-1:0]         i_dut_adr;
  logic                 i_dut_mw;
  logic [2*W+3:0]       i_vec_data;

  logic [DEPTH_LOG-1:0] o_vec_addr;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_pass;
  logic                 o_overrun;
  logic                 o_mismatch;
  logic [15:0]          o_err_count;
  logic [DEPTH_LOG:0]   o_vec_count;
  logic [DEPTH_LOG-1:0] o_first_err_idx;
  logic                 o_first_err_valid;

  // Checker side: observes the CPU and ROM, drives the results.
  modport slave (
    input  i_start, i_dut_wd, i_dut_adr, i_dut_mw, i_vec_data,
    output o_vec_addr, o_busy, o_done, o_pass, o_overrun, o_mismatch,
           o_err_count, o_vec_count, o_first_err_idx, o_first_err_valid
  );

  // Environment side: CPU, ROM and run control.
  modport master (
    output i_start, i_dut_wd, i_dut_adr, i_dut_mw, i_vec_data,
    input  o_vec_addr, o_busy, o_done, o_pass, o_overrun, o_mismatch,
           o_err_count, o_vec_count, o_first_err_idx, o_first_err_valid
  );
endinterface

// File: rtl/mips_bus_checker.sv
// Run-time checker for the MIPS data-memory bus.
// Walks a synchronous-read vector ROM, compares CPU writedata, address and
// memwrite against each vector (with per-field don't-care masks), counts
// mismatches, remembers the first failing vector index and reports
// done/pass/overrun. In WRITES_ONLY mode only memwrite cycles are compared.
module mips_bus_checker #(
  parameter int LOGWIDTH    = 5,
  parameter int DEPTH_LOG   = 10,
  parameter int WRITES_ONLY = 0
) (
  input logic              clk,
  input logic              reset,
  mips_bus_checker_if.slave bus
);

  localparam int W  = 2**LOGWIDTH;
  localparam int VW = 2*W + 4;

  localparam logic [DEPTH_LOG-1:0] LAST_IDX = {DEPTH_LOG{1'b1}};
  localparam logic [DEPTH_LOG-1:0] ADDR_ONE = DEPTH_LOG'(1);
  localparam logic [DEPTH_LOG:0]   CNT_ONE  = (DEPTH_LOG+1)'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;

  logic [DEPTH_LOG-1:0] r_vecAddr;
  logic [DEPTH_LOG-1:0] w_vecAddrNext;
  logic [DEPTH_LOG-1:0] r_idx;
  logic [DEPTH_LOG-1:0] w_idxNext;
  logic [15:0]          r_errCount;
  logic [15:0]          w_errCountNext;
  logic [DEPTH_LOG:0]   r_vecCount;
  logic [DEPTH_LOG:0]   w_vecCountNext;
  logic [DEPTH_LOG-1:0] r_firstErrIdx;
  logic [DEPTH_LOG-1:0] w_firstErrIdxNext;
  logic                 r_firstErrValid;
  logic                 w_firstErrValidNext;
  logic                 r_overrun;
  logic                 w_overrunNext;
  logic                 r_mismatch;
  logic                 w_mismatchNext;
  logic                 r_busy;
  logic                 w_busyNext;
  logic                 r_done;
  logic                 w_doneNext;
  logic                 r_pass;
  logic                 w_passNext;

  // While the checker waits for an eligible cycle the address register
  // holds, which means the ROM is already presenting the *next* vector.
  // The vector under test is therefore parked here and used instead of
  // the ROM output until the compare finally happens.
  logic [VW-1:0]        r_heldVec;
  logic [VW-1:0]        w_heldVecNext;
  logic                 r_useHeld;
  logic                 w_useHeldNext;

  logic [VW-1:0]        w_vec;
  logic [W-1:0]         w_vecWd;
  logic [W-1:0]         w_vecAdr;
  logic                 w_vecEnd;
  logic                 w_vecMaskWd;
  logic                 w_vecMaskAdr;
  logic                 w_vecMw;
  logic                 w_eligible;
  logic                 w_fail;

  assign w_vec        = r_useHeld ? r_heldVec : bus.i_vec_data;
  assign w_vecWd      = w_vec[2*W+3:W+4];
  assign w_vecAdr     = w_vec[W+3:4];
  assign w_vecEnd     = w_vec[3];
  assign w_vecMaskWd  = w_vec[2];
  assign w_vecMaskAdr = w_vec[1];
  assign w_vecMw      = w_vec[0];

  assign w_eligible = (WRITES_ONLY == 0) ? 1'b1 : bus.i_dut_mw;

  assign w_fail = (w_vecMaskWd  && (bus.i_dut_wd  != w_vecWd))  ||
                  (w_vecMaskAdr && (bus.i_dut_adr != w_vecAdr)) ||
                  (bus.i_dut_mw != w_vecMw);

  // Next-state and next-result logic; every register defaults to holding.
  always_comb begin
    w_stateNext         = r_state;
    w_vecAddrNext       = r_vecAddr;
    w_idxNext           = r_idx;
    w_errCountNext      = r_errCount;
    w_vecCountNext      = r_vecCount;
    w_firstErrIdxNext   = r_firstErrIdx;
    w_firstErrValidNext = r_firstErrValid;
    w_overrunNext       = r_overrun;
    w_mismatchNext      = 1'b0;
    w_heldVecNext       = r_heldVec;
    w_useHeldNext       = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (bus.i_start) begin
          w_stateNext         = PREFETCH;
          w_vecAddrNext       = '0;
          w_idxNext           = '0;
          w_errCountNext      = '0;
          w_vecCountNext      = '0;
          w_firstErrIdxNext   = '0;
          w_firstErrValidNext = 1'b0;
          w_overrunNext       = 1'b0;
        end
      end

      PREFETCH: begin
        w_vecAddrNext = ADDR_ONE;
        w_idxNext     = '0;
        w_stateNext   = RUN;
      end

      RUN: begin
        if (w_vecEnd) begin
          w_stateNext = DONE;
        end else if (w_eligible) begin
          if (w_fail) begin
            w_mismatchNext = 1'b1;
            if (r_errCount != 16'hFFFF) begin
              w_errCountNext = r_errCount + 16'd1;
            end
            if (!r_firstErrValid) begin
              w_firstErrIdxNext   = r_idx;
              w_firstErrValidNext = 1'b1;
            end
          end
          w_vecCountNext = r_vecCount + CNT_ONE;
          if (r_vecAddr != LAST_IDX) begin
            w_vecAddrNext = r_vecAddr + ADDR_ONE;
          end
          if (r_idx == LAST_IDX) begin
            w_overrunNext = 1'b1;
            w_stateNext   = DONE;
          end else begin
            w_idxNext = r_idx + ADDR_ONE;
          end
        end else begin
          w_heldVecNext = w_vec;
          w_useHeldNext = 1'b1;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase

    w_busyNext = (w_stateNext == PREFETCH) || (w_stateNext == RUN);
    w_doneNext = (w_stateNext == DONE);
    w_passNext = w_doneNext && (w_errCountNext == 16'd0) && !w_overrunNext;
  end

  // State and result registers; a low reset at any edge returns to IDLE
  // with every output cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_vecAddr       <= '0;
      r_idx           <= '0;
      r_errCount      <= '0;
      r_vecCount      <= '0;
      r_firstErrIdx   <= '0;
      r_firstErrValid <= 1'b0;
      r_overrun       <= 1'b0;
      r_mismatch      <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_heldVec       <= '0;
      r_useHeld       <= 1'b0;
    end else begin
      r_state         <= w_stateNext;
      r_vecAddr       <= w_vecAddrNext;
      r_idx           <= w_idxNext;
      r_errCount      <= w_errCountNext;
      r_vecCount      <= w_vecCountNext;
      r_firstErrIdx   <= w_firstErrIdxNext;
      r_firstErrValid <= w_firstErrValidNext;
      r_overrun       <= w_overrunNext;
      r_mismatch      <= w_mismatchNext;
      r_busy          <= w_busyNext;
      r_done          <= w_doneNext;
      r_pass          <= w_passNext;
      r_heldVec       <= w_heldVecNext;
      r_useHeld       <= w_useHeldNext;
    end
  end

  assign bus.o_vec_addr        = r_vecAddr;
  assign bus.o_busy            = r_busy;
  assign bus.o_done            = r_done;
  assign bus.o_pass            = r_pass;
  assign bus.o_overrun         = r_overrun;
  assign bus.o_mismatch        = r_mismatch;
  assign bus.o_err_count       = r_errCount;
  assign bus.o_vec_count       = r_vecCount;
  assign bus.o_first_err_idx   = r_firstErrIdx;
  assign bus.o_first_err_valid = r_firstErrValid;

endmodule

// File: tb/tb_mips_bus_checker.sv
// Bench for mips_bus_checker: three instances (every-cycle, writes-only,
// and a 4-deep ROM for overrun) share one vector ROM and one CPU stimulus
// stream; only the selected instance is started in each case.
module tb_mips_bus_checker;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  mips_bus_checker_if #(.LOGWIDTH(5), .DEPTH_LOG(5)) ifA ();
  mips_bus_checker_if #(.LOGWIDTH(5), .DEPTH_LOG(5)) ifB ();
  mips_bus_checker_if #(.LOGWIDTH(5), .DEPTH_LOG(2)) ifC ();

  mips_bus_checker #(.LOGWIDTH(5), .DEPTH_LOG(5), .WRITES_ONLY(0)) dutA (
    .clk(clk), .reset(reset), .bus(ifA));
  mips_bus_checker #(.LOGWIDTH(5), .DEPTH_LOG(5), .WRITES_ONLY(1)) dutB (
    .clk(clk), .reset(reset), .bus(ifB));
  mips_bus_checker #(.LOGWIDTH(5), .DEPTH_LOG(2), .WRITES_ONLY(0)) dutC (
    .clk(clk), .reset(reset), .bus(ifC));

  logic [67:0] rom [32];
  logic [31:0] drvWd  = '0;
  logic [31:0] drvAdr = '0;
  logic        drvMw  = 1'b0;
  logic        startA = 1'b0;
  logic        startB = 1'b0;
  logic        startC = 1'b0;

  assign ifA.i_start = startA;
  assign ifB.i_start = startB;
  assign ifC.i_start = startC;
  assign ifA.i_dut_wd = drvWd;
  assign ifB.i_dut_wd = drvWd;
  assign ifC.i_dut_wd = drvWd;
  assign ifA.i_dut_adr = drvAdr;
  assign ifB.i_dut_adr = drvAdr;
  assign ifC.i_dut_adr = drvAdr;
  assign ifA.i_dut_mw = drvMw;
  assign ifB.i_dut_mw = drvMw;
  assign ifC.i_dut_mw = drvMw;

  // Synchronous-read ROM: word appears one cycle after its address.
  always @(posedge clk) begin
    ifA.i_vec_data <= rom[ifA.o_vec_addr];
    ifB.i_vec_data <= rom[ifB.o_vec_addr];
    ifC.i_vec_data <= rom[{3'b000, ifC.o_vec_addr}];
  end

  int sel = 0;
  logic [31:0] obsBusy, obsDone, obsPass, obsOverrun, obsMis;
  logic [31:0] obsErr, obsVecCnt, obsFirstIdx, obsFirstValid, obsVecAddr;

  // Route the selected instance's results to the checking code.
  always_comb begin
    obsBusy = '0; obsDone = '0; obsPass = '0; obsOverrun = '0; obsMis = '0;
    obsErr = '0; obsVecCnt = '0; obsFirstIdx = '0; obsFirstValid = '0;
    obsVecAddr = '0;
    case (sel)
      0: begin
        obsBusy = 32'(ifA.o_busy); obsDone = 32'(ifA.o_done);
        obsPass = 32'(ifA.o_pass); obsOverrun = 32'(ifA.o_overrun);
        obsMis = 32'(ifA.o_mismatch); obsErr = 32'(ifA.o_err_count);
        obsVecCnt = 32'(ifA.o_vec_count); obsFirstIdx = 32'(ifA.o_first_err_idx);
        obsFirstValid = 32'(ifA.o_first_err_valid); obsVecAddr = 32'(ifA.o_vec_addr);
      end
      1: begin
        obsBusy = 32'(ifB.o_busy); obsDone = 32'(ifB.o_done);
        obsPass = 32'(ifB.o_pass); obsOverrun = 32'(ifB.o_overrun);
        obsMis = 32'(ifB.o_mismatch); obsErr = 32'(ifB.o_err_count);
        obsVecCnt = 32'(ifB.o_vec_count); obsFirstIdx = 32'(ifB.o_first_err_idx);
        obsFirstValid = 32'(ifB.o_first_err_valid); obsVecAddr = 32'(ifB.o_vec_addr);
      end
      default: begin
        obsBusy = 32'(ifC.o_busy); obsDone = 32'(ifC.o_done);
        obsPass = 32'(ifC.o_pass); obsOverrun = 32'(ifC.o_overrun);
        obsMis = 32'(ifC.o_mismatch); obsErr = 32'(ifC.o_err_count);
        obsVecCnt = 32'(ifC.o_vec_count); obsFirstIdx = 32'(ifC.o_first_err_idx);
        obsFirstValid = 32'(ifC.o_first_err_valid); obsVecAddr = 32'(ifC.o_vec_addr);
      end
    endcase
  end

  // Per-cycle CPU stimulus and reference-model expectations.
  logic [31:0] stimWd  [128];
  logic [31:0] stimAdr [128];
  logic        stimMw  [128];
  int          expMis  [128];
  int          expAddrAt [128];
  int expErr, expCnt, expFirstIdx, expFirstValid, expOverrun, expPass;
  int expDoneCyc, expAddr;

  int    total = 0;
  int    bad   = 0;
  string caseName = "reset";

  task automatic applyStimulus(input int c);
    drvWd  = stimWd[c];
    drvAdr = stimAdr[c];
    drvMw  = stimMw[c];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input int exp);
    total++;
    assert (got === 32'(exp)) else begin
      bad++;
      $error("[TB] FAIL %s/%s observed=%0d expected=%0d", caseName, tag, got, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, obsBusy, 0);
    checkOutput({tag, "_done"}, obsDone, 0);
    checkOutput({tag, "_pass"}, obsPass, 0);
    checkOutput({tag, "_overrun"}, obsOverrun, 0);
    checkOutput({tag, "_mismatch"}, obsMis, 0);
    checkOutput({tag, "_errCount"}, obsErr, 0);
    checkOutput({tag, "_vecCount"}, obsVecCnt, 0);
    checkOutput({tag, "_firstIdx"}, obsFirstIdx, 0);
    checkOutput({tag, "_firstValid"}, obsFirstValid, 0);
    checkOutput({tag, "_vecAddr"}, obsVecAddr, 0);
  endtask

  function automatic logic [67:0] mkVec(input logic [31:0] wd, input logic [31:0] adr,
                                        input logic e, input logic mwd,
                                        input logic madr, input logic mw);
    return {wd, adr, e, mwd, madr, mw};
  endfunction

  task automatic fillRom(input bit writes);
    for (int i = 0; i < 32; i++) begin
      rom[i] = mkVec($urandom, $urandom, 1'b0, ($urandom_range(3) != 0),
                     ($urandom_range(3) != 0), writes ? 1'b1 : 1'($urandom_range(1)));
    end
  endtask

  task automatic matchStim(input int n);
    for (int c = 0; c < n; c++) begin
      stimWd[c]  = rom[c % 32][67:36];
      stimAdr[c] = rom[c % 32][35:4];
      stimMw[c]  = rom[c % 32][0];
    end
  endtask

  task automatic corruptStim(input int n, input int pct, input bit allowMw);
    for (int c = 0; c < n; c++) begin
      if ($urandom_range(99) < pct) begin
        case ($urandom_range(allowMw ? 2 : 1))
          0: stimWd[c]  = stimWd[c]  ^ (32'd1 << $urandom_range(31));
          1: stimAdr[c] = stimAdr[c] ^ (32'd1 << $urandom_range(31));
          default: stimMw[c] = ~stimMw[c];
        endcase
      end
    end
  endtask

  // Writes-only stream: idle cycles (memwrite low) before each write.
  task automatic buildWritesStim(input int nVec, input int fixedIdle, input int pct,
                                 output int n);
    int c = 0;
    for (int v = 0; v < nVec; v++) begin
      int idl = (fixedIdle >= 0) ? fixedIdle : int'($urandom_range(4));
      for (int k = 0; k < idl; k++) begin
        stimWd[c] = $urandom; stimAdr[c] = $urandom; stimMw[c] = 1'b0; c++;
      end
      stimWd[c] = rom[v][67:36]; stimAdr[c] = rom[v][35:4]; stimMw[c] = 1'b1;
      if ($urandom_range(99) < pct) stimWd[c] = stimWd[c] ^ 32'h1;
      c++;
    end
    for (int k = 0; k < 3; k++) begin
      stimWd[c] = $urandom; stimAdr[c] = $urandom; stimMw[c] = 1'b0; c++;
    end
    n = c;
  endtask

  // Reference model: walk vectors in order against the cycle stream.
  task automatic model(input int wo, input int depth, input int n);
    int i = 0;
    logic [67:0] v;
    bit isBad;
    expErr = 0; expCnt = 0; expFirstIdx = 0; expFirstValid = 0;
    expOverrun = 0; expDoneCyc = -1;
    for (int c = 0; c < n; c++) begin
      v = rom[i];
      expMis[c] = 0;
      expAddrAt[c] = (i + 1 > depth - 1) ? depth - 1 : i + 1;
      if (v[3]) begin
        expDoneCyc = c;
        break;
      end
      if (wo == 0 || stimMw[c]) begin
        isBad = (v[2] && stimWd[c] != v[67:36]) || (v[1] && stimAdr[c] != v[35:4]) ||
                (stimMw[c] != v[0]);
        if (isBad) begin
          expMis[c] = 1;
          if (expErr != 65535) expErr++;
          if (expFirstValid == 0) begin
            expFirstIdx = i;
            expFirstValid = 1;
          end
        end
        expCnt++;
        if (i == depth - 1) begin
          expOverrun = 1;
          expDoneCyc = c;
          break;
        end
        i++;
      end
    end
    expPass = (expDoneCyc >= 0 && expErr == 0 && expOverrun == 0) ? 1 : 0;
    expAddr = (expCnt + 1 > depth - 1) ? depth - 1 : expCnt + 1;
  endtask

  task automatic setStart(input int s, input bit v);
    startA = v && (s == 0);
    startB = v && (s == 1);
    startC = v && (s == 2);
  endtask

  task automatic runCase(input string name, input int s, input int wo, input int depth,
                         input int n, input int resetAt, input int startAt);
    int lastC;
    model(wo, depth, n);
    lastC = (expDoneCyc < 0) ? n - 1 : expDoneCyc;
    caseName = name;
    sel = s;
    @(negedge clk);
    setStart(s, 1'b1);
    @(negedge clk);
    setStart(s, 1'b0);
    checkOutput("prefetch_busy", obsBusy, 1);
    checkOutput("prefetch_done", obsDone, 0);
    checkOutput("prefetch_errCleared", obsErr, 0);
    checkOutput("prefetch_cntCleared", obsVecCnt, 0);
    for (int c = 0; c <= lastC; c++) begin
      @(negedge clk);
      if (c > 0) checkOutput("mismatch", obsMis, expMis[c-1]);
      checkOutput("run_busy", obsBusy, 1);
      checkOutput("run_vecAddr", obsVecAddr, expAddrAt[c]);
      applyStimulus(c);
      setStart(s, c == startAt);
      if (c == resetAt) begin
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("midReset");
        reset = 1'b1;
        return;
      end
    end
    @(negedge clk);
    setStart(s, 1'b0);
    drvMw = 1'b0;
    checkOutput("mismatch_last", obsMis, expMis[lastC]);
    checkOutput("done", obsDone, 1);
    checkOutput("busy_end", obsBusy, 0);
    checkOutput("pass", obsPass, expPass);
    checkOutput("overrun", obsOverrun, expOverrun);
    checkOutput("errCount", obsErr, expErr);
    checkOutput("vecCount", obsVecCnt, expCnt);
    checkOutput("firstIdx", obsFirstIdx, expFirstIdx);
    checkOutput("firstValid", obsFirstValid, expFirstValid);
    checkOutput("vecAddr_end", obsVecAddr, expAddr);
  endtask

  initial begin
    int n;
    fillRom(1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkAllZero("reset");
    end
    reset = 1'b1;
    @(negedge clk);

    // Three exact vectors then end, matching CPU.
    fillRom(1'b0);
    for (int i = 0; i < 3; i++) rom[i] = mkVec(32'h7, 32'h54, 1'b0, 1'b1, 1'b1, 1'b1);
    rom[3] = mkVec($urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    matchStim(8);
    runCase("exact", 0, 0, 32, 8, -1, -1);

    // Wrong address on vector 1, then the same with its address masked.
    stimAdr[1] = 32'h50;
    runCase("badAdr", 0, 0, 32, 8, -1, -1);
    rom[1][1] = 1'b0;
    runCase("maskAdr", 0, 0, 32, 8, -1, -1);

    // Random vectors with corruption; start pulsed mid-run, then rerun from DONE.
    fillRom(1'b0);
    n = $urandom_range(5, 20);
    rom[n] = mkVec($urandom, $urandom, 1'b1, 1'b1, 1'b1, 1'b1);
    matchStim(n + 4);
    corruptStim(n, 30, 1'b1);
    runCase("random", 0, 0, 32, n + 4, -1, 2);
    runCase("rerun", 0, 0, 32, n + 4, -1, -1);

    // Reset mid-run at vector 2, then a clean run from vector 0.
    fillRom(1'b0);
    rom[10] = mkVec($urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    matchStim(14);
    corruptStim(14, 20, 1'b1);
    runCase("midReset", 0, 0, 32, 14, 2, -1);
    runCase("afterReset", 0, 0, 32, 14, -1, -1);

    // Writes-only: two writes separated by idle cycles, then random writes.
    fillRom(1'b1);
    rom[2] = mkVec($urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    buildWritesStim(2, 5, 0, n);
    runCase("writesIdle", 1, 1, 32, n, -1, -1);
    fillRom(1'b1);
    rom[6] = mkVec($urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    buildWritesStim(6, -1, 40, n);
    runCase("writesRandom", 1, 1, 32, n, -1, -1);

    // Four-deep ROM without end bit: overrun, clean then corrupted, then with end.
    fillRom(1'b0);
    matchStim(8);
    runCase("overrun", 2, 0, 4, 8, -1, -1);
    corruptStim(4, 60, 1'b1);
    runCase("overrunErr", 2, 0, 4, 8, -1, -1);
    rom[2] = mkVec($urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    matchStim(8);
    runCase("shortEnd", 2, 0, 4, 8, -1, -1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
